pipeline_hazard_ctrl: RTL

Hazard and stall sequencer for the 5-stage MIPS pipeline: it sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush controls. It inserts a one-cycle bubble on load-use hazards and squashes the three younger stages when a branch resolves taken in MEM. It freezes the whole pipeline while the data memory is busy, and traps to a fault state when that wait exceeds a bound. Two saturating counters record stall cycles and branch flushes for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status inputs and hazard control outputs
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // hazard controller side: observes pipeline status, drives register controls
  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_freeze, mem_timeout, stall_cnt, flush_cnt
  );

  // pipeline side: presents status, consumes controls
  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_freeze, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / branch / memory-wait hazard sequencer
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.master hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_q, flush_q;

  logic load_use, taken, mem_busy;
  logic run_rules;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
  logic flush_inc;

  assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  assign taken    = hz.mem_branch && hz.mem_zero;
  assign mem_busy = (hz.mem_memread || hz.mem_memwrite) && !hz.dmem_ready;

  // Decide this cycle's controls and next state; the RUN taken/load-use rules
  // are shared with the MEM_WAIT completion cycle through run_rules.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    flush_inc   = 1'b0;
    run_rules   = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      wait_d      = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            state_d     = MEM_WAIT;
            wait_d      = '0;
          end else begin
            run_rules = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!hz.dmem_ready) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
              state_d = FAULT;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end else begin
            run_rules = 1'b1;
            state_d   = RUN;
          end
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_freeze = 1'b1;
        end
      endcase

      if (run_rules) begin
        if (taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  // State, wait counter, sticky fault flag and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= (state_d == FAULT);
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.pipe_freeze = pipe_freeze;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule
